// File: rtl/mem_port_sequencer.sv
// Single-port memory sequencer: arbitrates fetch and data requests onto one
// 16-bit memory bus and runs each read/write handshake as a registered FSM.
//
// Handshake contract: a requester raises *_req and holds it (with stable
// address/data) until it sees its one-cycle *_done pulse, then drops it in the
// following cycle; the bus side completes a read when inputReady is high on a
// clock edge and a write when ackOutput is high on a clock edge.
module mem_port_sequencer #(
    parameter int WORD_SIZE = 16,
    parameter int TIMEOUT   = 255,
    parameter int TO_W      = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 f_req,
    input  logic [WORD_SIZE-1:0] f_addr,
    output logic                 f_done,
    output logic [WORD_SIZE-1:0] f_rdata,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [WORD_SIZE-1:0] d_addr,
    input  logic [WORD_SIZE-1:0] d_wdata,
    output logic                 d_done,
    output logic [WORD_SIZE-1:0] d_rdata,
    output logic                 err,
    output logic                 readM,
    output logic                 writeM,
    output logic [WORD_SIZE-1:0] address,
    inout  wire  [WORD_SIZE-1:0] data,
    input  logic                 inputReady,
    input  logic                 ackOutput,
    output logic [2:0]           dbg_state
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        F_RD = 3'd1,
        D_RD = 3'd2,
        D_WR = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    state_t               state_q, state_d;
    logic                 read_q, read_d;
    logic                 write_q, write_d;
    logic [WORD_SIZE-1:0] addr_q, addr_d;
    logic [WORD_SIZE-1:0] wdata_q, wdata_d;
    logic [WORD_SIZE-1:0] f_rdata_q, f_rdata_d;
    logic [WORD_SIZE-1:0] d_rdata_q, d_rdata_d;
    logic [TO_W-1:0]      cnt_q, cnt_d;
    logic                 fair_q, fair_d;
    logic                 f_done_q, f_done_d;
    logic                 d_done_q, d_done_d;
    logic                 err_q, err_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            read_q    <= 1'b0;
            write_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            f_rdata_q <= '0;
            d_rdata_q <= '0;
            cnt_q     <= '0;
            fair_q    <= 1'b0;
            f_done_q  <= 1'b0;
            d_done_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            read_q    <= read_d;
            write_q   <= write_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            f_rdata_q <= f_rdata_d;
            d_rdata_q <= d_rdata_d;
            cnt_q     <= cnt_d;
            fair_q    <= fair_d;
            f_done_q  <= f_done_d;
            d_done_q  <= d_done_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        read_d    = read_q;
        write_d   = write_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        f_rdata_d = f_rdata_q;
        d_rdata_d = d_rdata_q;
        cnt_d     = cnt_q;
        fair_d    = fair_q;
        f_done_d  = 1'b0;
        d_done_d  = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            IDLE: begin
                // Data has priority unless the previous grant went to data while fetch waited.
                if (d_req && !(fair_q && f_req)) begin
                    addr_d  = d_addr;
                    wdata_d = d_wdata;
                    cnt_d   = '0;
                    if (f_req) begin
                        fair_d = 1'b1;
                    end
                    if (d_we) begin
                        state_d = D_WR;
                        write_d = 1'b1;
                    end else begin
                        state_d = D_RD;
                        read_d  = 1'b1;
                    end
                end else if (f_req) begin
                    addr_d  = f_addr;
                    cnt_d   = '0;
                    fair_d  = 1'b0;
                    state_d = F_RD;
                    read_d  = 1'b1;
                end
            end

            F_RD, D_RD: begin
                if (inputReady) begin
                    if (state_q == F_RD) begin
                        f_rdata_d = data;
                        f_done_d  = 1'b1;
                    end else begin
                        d_rdata_d = data;
                        d_done_d  = 1'b1;
                    end
                    read_d  = 1'b0;
                    state_d = DONE;
                end else if (cnt_q == TO_LAST) begin
                    f_done_d = (state_q == F_RD);
                    d_done_d = (state_q == D_RD);
                    err_d    = 1'b1;
                    read_d   = 1'b0;
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end

            D_WR: begin
                if (ackOutput) begin
                    d_done_d = 1'b1;
                    write_d  = 1'b0;
                    state_d  = DONE;
                end else if (cnt_q == TO_LAST) begin
                    d_done_d = 1'b1;
                    err_d    = 1'b1;
                    write_d  = 1'b0;
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
                read_d  = 1'b0;
                write_d = 1'b0;
            end
        endcase
    end

    // The bus is driven only while the write handshake is in flight.
    assign data      = (state_q == D_WR) ? wdata_q : {WORD_SIZE{1'bz}};
    assign readM     = read_q;
    assign writeM    = write_q;
    assign address   = addr_q;
    assign f_rdata   = f_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign f_done    = f_done_q;
    assign d_done    = d_done_q;
    assign err       = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_port_sequencer.sv
// Directed bench for mem_port_sequencer: table of single transactions plus
// hand-written arbitration, timeout, reset and spurious-response sequences.
module tb_mem_port_sequencer;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_DONE = 3'd4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        f_req = 1'b0;
    logic [15:0] f_addr = '0;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [15:0] d_addr = '0;
    logic [15:0] d_wdata = '0;
    logic        inputReady = 1'b0;
    logic        ackOutput = 1'b0;
    logic        mem_drv = 1'b0;
    logic [15:0] mem_val = '0;
    logic        f_done, d_done, err, readM, writeM;
    logic [15:0] f_rdata, d_rdata, address;
    logic [2:0]  dbg_state;
    wire  [15:0] data;

    assign data = mem_drv ? mem_val : 16'hzzzz;

    mem_port_sequencer dut (
        .clk(clk), .reset_n(reset_n),
        .f_req(f_req), .f_addr(f_addr), .f_done(f_done), .f_rdata(f_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata), .err(err),
        .readM(readM), .writeM(writeM), .address(address), .data(data),
        .inputReady(inputReady), .ackOutput(ackOutput), .dbg_state(dbg_state)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];
    logic [15:0] model_f = '0;
    logic [15:0] model_d = '0;

    typedef struct {
        logic        is_data;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        int          lat;
        logic [15:0] rdata;
        logic        exp_write;
        logic [15:0] exp_addr;
        logic [15:0] exp_rdata;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Wait for the strobe, check it, answer after lat strobe cycles (lat=0: never).
    // Returns at the negedge of the DONE cycle with cnt = strobe-high cycles.
    task automatic serve(input logic exp_write, input logic [15:0] exp_addr,
                         input logic [15:0] exp_wdata, input int lat,
                         input logic [15:0] rdata, output int cnt);
        bit found = 0;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (readM || writeM) begin
                found = 1;
                break;
            end
        end
        if (!found) begin
            check("strobe_seen", 0, 1);
            return;
        end
        check("strobe_kind", {31'd0, writeM}, {31'd0, exp_write});
        check("address", {16'd0, address}, {16'd0, exp_addr});
        if (exp_write) check("wr_bus_data", {16'd0, data}, {16'd0, exp_wdata});
        cnt = 1;
        forever begin
            if (readM && writeM) check("strobe_exclusive", 1, 0);
            if (lat != 0 && cnt == lat) begin
                check("address_held", {16'd0, address}, {16'd0, exp_addr});
                if (exp_write) begin
                    ackOutput = 1'b1;
                end else begin
                    inputReady = 1'b1;
                    mem_drv = 1'b1;
                    mem_val = rdata;
                end
                @(negedge clk);
                ackOutput = 1'b0;
                inputReady = 1'b0;
                mem_drv = 1'b0;
                break;
            end
            @(negedge clk);
            if (!(readM || writeM)) break;
            cnt++;
            if (cnt > 400) begin
                check("strobe_bounded", 0, 1);
                break;
            end
        end
    endtask

    // Called at the DONE negedge; checks the pulse, rdata scoreboard, then the idle cycle.
    task automatic expect_done(input logic ef, input logic ed, input logic eerr);
        logic [15:0] exp;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
        check("f_done", {31'd0, f_done}, {31'd0, ef});
        check("d_done", {31'd0, d_done}, {31'd0, ed});
        check("err", {31'd0, err}, {31'd0, eerr});
        check("strobes_low_done", {30'd0, readM, writeM}, 0);
        check("state_done", {29'd0, dbg_state}, {29'd0, S_DONE});
        if (ef) begin
            check("f_rdata", {16'd0, f_rdata}, {16'd0, exp});
            check("d_rdata_kept", {16'd0, d_rdata}, {16'd0, model_d});
            model_f = exp;
        end else begin
            check("d_rdata", {16'd0, d_rdata}, {16'd0, exp});
            check("f_rdata_kept", {16'd0, f_rdata}, {16'd0, model_f});
            model_d = exp;
        end
        @(negedge clk);
        check("done_one_cycle", {29'd0, f_done, d_done, err}, 0);
        check("state_idle_after", {29'd0, dbg_state}, {29'd0, S_IDLE});
    endtask

    initial begin
        int cnt;
        bit saw_done;

        vecs[0] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 3, 16'h6A05, 1'b0, 16'h0010, 16'h6A05};
        vecs[1] = '{1'b1, 1'b1, 16'h0040, 16'hBEEF, 2, 16'h0000, 1'b1, 16'h0040, 16'h0000};
        vecs[2] = '{1'b1, 1'b0, 16'h0041, 16'h0000, 1, 16'h1357, 1'b0, 16'h0041, 16'h1357};
        vecs[3] = '{1'b0, 1'b0, 16'h0011, 16'h0000, 4, 16'h9ABC, 1'b0, 16'h0011, 16'h9ABC};
        vecs[4] = '{1'b1, 1'b1, 16'hFFFF, 16'h0001, 1, 16'h0000, 1'b1, 16'hFFFF, 16'h1357};
        vecs[5] = '{1'b1, 1'b0, 16'h00FF, 16'h0000, 5, 16'hC0DE, 1'b0, 16'h00FF, 16'hC0DE};

        // reset
        repeat (3) @(negedge clk);
        check("rst_readM", {31'd0, readM}, 0);
        check("rst_writeM", {31'd0, writeM}, 0);
        check("rst_dones", {29'd0, f_done, d_done, err}, 0);
        check("rst_address", {16'd0, address}, 0);
        check("rst_f_rdata", {16'd0, f_rdata}, 0);
        check("rst_d_rdata", {16'd0, d_rdata}, 0);
        check("rst_state", {29'd0, dbg_state}, {29'd0, S_IDLE});
        reset_n = 1'b1;
        @(negedge clk);

        // table of single transactions
        for (int i = 0; i < 6; i++) begin
            if (vecs[i].is_data) begin
                d_req = 1'b1;
                d_we = vecs[i].we;
                d_addr = vecs[i].addr;
                d_wdata = vecs[i].wdata;
            end else begin
                f_req = 1'b1;
                f_addr = vecs[i].addr;
            end
            exp_q.push_back(vecs[i].exp_rdata);
            serve(vecs[i].exp_write, vecs[i].exp_addr, vecs[i].wdata, vecs[i].lat, vecs[i].rdata, cnt);
            check("strobe_cycles", cnt, vecs[i].lat);
            f_req = 1'b0;
            d_req = 1'b0;
            d_addr = 16'h5555;
            expect_done(!vecs[i].is_data, vecs[i].is_data, 1'b0);
            if (vecs[i].we) begin
                mem_drv = 1'b1;
                mem_val = 16'h1234;
                #1;
                check("bus_released", {16'd0, data}, 32'h1234);
                mem_drv = 1'b0;
            end
        end

        // spurious responses in IDLE
        inputReady = 1'b1;
        ackOutput = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("spurious_no_done", {29'd0, f_done, d_done, err}, 0);
            check("spurious_idle", {29'd0, dbg_state, readM, writeM} , {29'd0, S_IDLE, 2'b00});
        end
        inputReady = 1'b0;
        ackOutput = 1'b0;
        @(negedge clk);

        // simultaneous requests: data first, then fetch, then the second data request
        f_req = 1'b1;
        f_addr = 16'h0100;
        d_req = 1'b1;
        d_we = 1'b0;
        d_addr = 16'h0020;
        exp_q.push_back(16'h2222);
        serve(1'b0, 16'h0020, 16'h0000, 1, 16'h2222, cnt);
        d_req = 1'b0;
        expect_done(1'b0, 1'b1, 1'b0);
        d_req = 1'b1;
        d_addr = 16'h0030;
        exp_q.push_back(16'h4444);
        serve(1'b0, 16'h0100, 16'h0000, 2, 16'h4444, cnt);
        f_req = 1'b0;
        expect_done(1'b1, 1'b0, 1'b0);
        exp_q.push_back(16'h3333);
        serve(1'b0, 16'h0030, 16'h0000, 1, 16'h3333, cnt);
        d_req = 1'b0;
        expect_done(1'b0, 1'b1, 1'b0);

        // timeout: read never answered, d_rdata keeps 0x3333
        d_req = 1'b1;
        d_we = 1'b0;
        d_addr = 16'h0050;
        exp_q.push_back(16'h3333);
        serve(1'b0, 16'h0050, 16'h0000, 0, 16'h0000, cnt);
        check("timeout_cycles", cnt, 255);
        d_req = 1'b0;
        expect_done(1'b0, 1'b1, 1'b1);

        // asynchronous reset in the middle of a fetch
        f_req = 1'b1;
        f_addr = 16'h0200;
        @(negedge clk);
        @(negedge clk);
        check("mid_readM_up", {31'd0, readM}, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_readM_drop", {31'd0, readM}, 0);
        check("async_state_idle", {29'd0, dbg_state}, {29'd0, S_IDLE});
        f_req = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        saw_done = 0;
        repeat (4) begin
            @(negedge clk);
            if (f_done || d_done || err) saw_done = 1;
        end
        check("no_done_after_reset", {31'd0, saw_done}, 0);
        check("idle_after_reset", {29'd0, dbg_state}, {29'd0, S_IDLE});
        check("f_rdata_reset", {16'd0, f_rdata}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
